// File: rtl/dft_power_avg_pkg.sv
// Shared definitions for the streaming power-spectrum averager.
//   LAT    : input-sample to result latency in clock cycles.
//   clog2  : ceiling log2, usable in parameter expressions.
//   pwr_t  : unsigned power word for the default 16-bit datapath.
//   acc_t  : accumulator word for the default datapath (16-frame headroom).
package dft_pkg;

  localparam int LAT        = 4;
  localparam int DFT_DATA_W = 16;
  localparam int DFT_AVG_W  = 4;

  typedef logic [2*DFT_DATA_W-1:0]           pwr_t;
  typedef logic [2*DFT_DATA_W+DFT_AVG_W-1:0] acc_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dft_acc_ram.sv
// Per-bin accumulator storage: simple dual-port RAM, one write port and one
// read port, registered read data (one cycle), no reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (sampled every cycle)
//   rdata_o : read data, valid the cycle after raddr_i is presented
module dft_acc_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int WIDTH  = 36
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dft_power_avg.sv
// Streaming per-bin power averager placed after the FFT core. Each complex bin
// is squared (re^2 + im^2) and averaged over 2^k consecutive frames; the running
// sums live in an on-chip accumulator RAM. Latency from sample to result is 4.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_sop    : input qualifier and bin-0 marker
//   data_re, data_im    : signed complex bin value
//   avg_log2            : averaging exponent k (latched at each batch start)
//   out_valid/sop/eop   : result qualifier, bin 0 and last-bin markers
//   out_bin, result     : bin index and floor mean power of that bin
//   frame_err           : one-cycle pulse when a sop arrives mid-frame
module dft_power_avg
  import dft_pkg::*;
#(
  parameter  int DATA_W   = 16,
  parameter  int FFT_SIZE = 1024,
  parameter  int AVG_W    = 4,
  localparam int BIN_W    = clog2(FFT_SIZE),
  localparam int ACC_W    = 2*DATA_W + AVG_W,
  localparam int K_W      = clog2(AVG_W + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sop,
  input  logic signed [DATA_W-1:0] data_re,
  input  logic signed [DATA_W-1:0] data_im,
  input  logic [K_W-1:0]           avg_log2,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [BIN_W-1:0]         out_bin,
  output logic [2*DATA_W-1:0]      result,
  output logic                     frame_err
);

  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(FFT_SIZE - 1);
  localparam logic [AVG_W:0]   ONE      = (AVG_W+1)'(1);

  function automatic logic [K_W-1:0] clamp_k(input logic [K_W-1:0] v);
    if (int'(v) > AVG_W) return K_W'(AVG_W);
    return v;
  endfunction

  // Floor division by 2^k; the mean never exceeds one frame's power.
  function automatic logic [2*DATA_W-1:0] mean_of(input logic [ACC_W-1:0] acc,
                                                   input logic [K_W-1:0]   k);
    return (2*DATA_W)'(acc >> k);
  endfunction

  // Framing / batch control
  logic             synced_q, synced_d;
  logic [BIN_W-1:0] bin_cnt_q, bin_d, bin_cur;
  logic [AVG_W-1:0] frame_cnt_q, frame_d, frame_cur;
  logic [K_W-1:0]   k_q, k_d, k_cur;
  logic [AVG_W:0]   last_idx;
  logic             sop_in, restart, accept, err_d, first_cur, last_cur;
  logic             frame_err_q;

  always_comb begin
    sop_in    = in_valid & in_sop;
    // A sop before sync or away from bin 0 starts a fresh batch.
    restart   = sop_in & (~synced_q | (bin_cnt_q != '0));
    err_d     = sop_in & synced_q & (bin_cnt_q != '0);
    accept    = in_valid & (synced_q | in_sop);
    bin_cur   = restart ? '0 : bin_cnt_q;
    frame_cur = restart ? '0 : frame_cnt_q;
    // k is sampled only on bin 0 of frame 0 and held for the whole batch.
    k_cur     = ((bin_cur == '0) && (frame_cur == '0)) ? clamp_k(avg_log2) : k_q;
    last_idx  = (ONE << k_cur) - ONE;
    first_cur = (frame_cur == '0);
    last_cur  = ({1'b0, frame_cur} == last_idx);

    synced_d = synced_q;
    bin_d    = bin_cnt_q;
    frame_d  = frame_cnt_q;
    k_d      = k_q;
    if (accept) begin
      synced_d = 1'b1;
      k_d      = k_cur;
      if (bin_cur == BIN_LAST) begin
        bin_d   = '0;
        frame_d = last_cur ? '0 : frame_cur + 1'b1;
      end else begin
        bin_d   = bin_cur + 1'b1;
        frame_d = frame_cur;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      synced_q    <= 1'b0;
      bin_cnt_q   <= '0;
      frame_cnt_q <= '0;
      k_q         <= '0;
      frame_err_q <= 1'b0;
    end else begin
      synced_q    <= synced_d;
      bin_cnt_q   <= bin_d;
      frame_cnt_q <= frame_d;
      k_q         <= k_d;
      frame_err_q <= err_d;
    end
  end

  // Pipeline valids
  logic vld_p1_q, vld_p2_q, vld_p3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p1_q <= accept;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
    end
  end

  // Pipeline data (not reset; qualified by the matching valid)
  logic signed [DATA_W-1:0]   re_p1_q, im_p1_q;
  logic [BIN_W-1:0]           bin_p1_q, bin_p2_q, bin_p3_q;
  logic                       first_p1_q, first_p2_q, first_p3_q;
  logic                       last_p1_q, last_p2_q, last_p3_q;
  logic [K_W-1:0]             k_p1_q, k_p2_q, k_p3_q;
  logic signed [2*DATA_W-1:0] re_ext_d, im_ext_d, sq_re_d, sq_im_d;
  logic signed [2*DATA_W-1:0] sq_re_p2_q, sq_im_p2_q;
  logic [2*DATA_W-1:0]        pwr_d, pwr_p3_q;

  always_comb begin
    re_ext_d = (2*DATA_W)'(re_p1_q);
    im_ext_d = (2*DATA_W)'(im_p1_q);
    sq_re_d  = re_ext_d * re_ext_d;
    sq_im_d  = im_ext_d * im_ext_d;
    // Both squares are non-negative; the sum peaks at 2^(2*DATA_W-1).
    pwr_d    = $unsigned(sq_re_p2_q) + $unsigned(sq_im_p2_q);
  end

  always_ff @(posedge clk) begin
    // S1: input register
    re_p1_q    <= data_re;
    im_p1_q    <= data_im;
    bin_p1_q   <= bin_cur;
    first_p1_q <= first_cur;
    last_p1_q  <= last_cur;
    k_p1_q     <= k_cur;
    // S2: squares; accumulator read is addressed from this stage
    sq_re_p2_q <= sq_re_d;
    sq_im_p2_q <= sq_im_d;
    bin_p2_q   <= bin_p1_q;
    first_p2_q <= first_p1_q;
    last_p2_q  <= last_p1_q;
    k_p2_q     <= k_p1_q;
    // S3: power; RAM read data lines up with this stage
    pwr_p3_q   <= pwr_d;
    bin_p3_q   <= bin_p2_q;
    first_p3_q <= first_p2_q;
    last_p3_q  <= last_p2_q;
    k_p3_q     <= k_p2_q;
  end

  // S4: accumulate, write back or emit the mean
  logic [ACC_W-1:0] ram_rdata, acc_d;
  logic             emit_d, we_d;

  always_comb begin
    acc_d  = first_p3_q ? ACC_W'(pwr_p3_q) : ram_rdata + ACC_W'(pwr_p3_q);
    emit_d = vld_p3_q & last_p3_q;
    we_d   = vld_p3_q & ~last_p3_q;
  end

  dft_acc_ram #(
    .DEPTH  (FFT_SIZE),
    .ADDR_W (BIN_W),
    .WIDTH  (ACC_W)
  ) u_acc_ram (
    .clk_i   (clk),
    .we_i    (we_d),
    .waddr_i (bin_p3_q),
    .wdata_i (acc_d),
    .raddr_i (bin_p2_q),
    .rdata_o (ram_rdata)
  );

  logic                out_valid_q, out_sop_q, out_eop_q;
  logic [BIN_W-1:0]    out_bin_q;
  logic [2*DATA_W-1:0] result_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_bin_q   <= '0;
      result_q    <= '0;
    end else begin
      out_valid_q <= emit_d;
      out_sop_q   <= emit_d & (bin_p3_q == '0);
      out_eop_q   <= emit_d & (bin_p3_q == BIN_LAST);
      if (emit_d) begin
        out_bin_q <= bin_p3_q;
        result_q  <= mean_of(acc_d, k_p3_q);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_bin   = out_bin_q;
  assign result    = result_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_dft_power_avg.sv
module tb_dft_power_avg;
  import dft_pkg::*;

  localparam int DATA_W = 16;
  localparam int N      = 8;
  localparam int AVG_W  = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_sop = 1'b0;
  logic signed [DATA_W-1:0] data_re = '0;
  logic signed [DATA_W-1:0] data_im = '0;
  logic [2:0]               avg_log2 = '0;
  logic                     out_valid, out_sop, out_eop, frame_err;
  logic [2:0]               out_bin;
  logic [2*DATA_W-1:0]      result;

  dft_power_avg #(.DATA_W(DATA_W), .FFT_SIZE(N), .AVG_W(AVG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
    .data_re(data_re), .data_im(data_im), .avg_log2(avg_log2),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_bin(out_bin), .result(result), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: per-bin running sums over a batch of 2^k frames.
  typedef struct { int due; int bin; longint res; } exp_t;
  typedef struct { int bin; longint res; bit sop; bit eop; } cap_t;
  typedef struct { int re; int im; longint exp; } vec_t;

  exp_t   expq[$];
  int     errq[$];
  cap_t   cap[$];
  cap_t   ref_cap[$];
  int     err_seen = 0;
  bit     m_synced = 0;
  int     m_bin = 0, m_frame = 0, m_k = 0;
  longint m_sum[N];

  function automatic void model_step(bit v, bit s, int re, int im, int a, int c);
    longint p;
    exp_t e;
    if (!v) return;
    if (s && (!m_synced || m_bin != 0)) begin
      if (m_synced) errq.push_back(c + 1);
      m_synced = 1; m_bin = 0; m_frame = 0;
    end
    if (!m_synced) return;
    if (m_bin == 0 && m_frame == 0) m_k = (a > AVG_W) ? AVG_W : a;
    p = longint'(re) * re + longint'(im) * im;
    m_sum[m_bin] = (m_frame == 0) ? p : m_sum[m_bin] + p;
    if (m_frame == (1 << m_k) - 1) begin
      e.due = c + LAT; e.bin = m_bin; e.res = m_sum[m_bin] >> m_k;
      expq.push_back(e);
    end
    m_bin++;
    if (m_bin == N) begin
      m_bin = 0;
      m_frame++;
      if (m_frame == (1 << m_k)) m_frame = 0;
    end
  endfunction

  task automatic drive(input bit v, input bit s, input int re, input int im, input int a);
    @(negedge clk);
    in_valid = v; in_sop = s;
    data_re = 16'(re); data_im = 16'(im); avg_log2 = 3'(a);
    if (!rst) model_step(v, s, re, im, a, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic drive_frame(input int re, input int im, input int a);
    for (int b = 0; b < N; b++) drive(1, b == 0, re, im, a);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; in_sop = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sop", out_sop, 0);
    chk("rst_out_eop", out_eop, 0);
    chk("rst_out_bin", out_bin, 0);
    chk("rst_result", result, 0);
    chk("rst_frame_err", frame_err, 0);
    expq.delete(); errq.delete();
    m_synced = 0; m_bin = 0; m_frame = 0; m_k = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // Output monitor: timing and content against the model, every cycle.
  always @(negedge clk) begin : mon
    bit   ev, ee;
    cap_t c;
    if (!rst) begin
      ev = (expq.size() > 0) && (expq[0].due == cyc);
      if (out_valid || ev) begin
        chk("out_valid_timing", out_valid, ev);
        if (out_valid && ev) begin
          chk("out_bin", out_bin, expq[0].bin);
          chk("out_result", result, expq[0].res);
          chk("out_sop", out_sop, expq[0].bin == 0);
          chk("out_eop", out_eop, expq[0].bin == N - 1);
        end
        if (ev) void'(expq.pop_front());
      end
      if (out_valid) begin
        c.bin = out_bin; c.res = result; c.sop = out_sop; c.eop = out_eop;
        cap.push_back(c);
      end
      ee = (errq.size() > 0) && (errq[0] == cyc);
      if (frame_err || ee) begin
        chk("frame_err_pulse", frame_err, ee);
        if (ee) void'(errq.pop_front());
      end
      if (frame_err) err_seen++;
    end
  end

  vec_t tbl[N];
  int   rre[4*N];
  int   rim[4*N];
  int   e0;

  initial begin
    tbl[0] = '{3, -4, 25};
    tbl[1] = '{-32768, -32768, 64'h8000_0000};
    tbl[2] = '{32767, 0, 64'h3FFF_0001};
    tbl[3] = '{6, 8, 100};
    tbl[4] = '{0, 20, 400};
    tbl[5] = '{-1, -1, 2};
    tbl[6] = '{0, 0, 0};
    tbl[7] = '{-32768, 32767, 64'h7FFF_0001};

    apply_reset();

    // k=0: one frame from the table, each bin output directly.
    cap.delete();
    for (int i = 0; i < N; i++) drive(1, i == 0, tbl[i].re, tbl[i].im, 0);
    idle(6);
    chk("k0_count", cap.size(), N);
    for (int i = 0; i < N && i < cap.size(); i++) begin
      chk("k0_result", cap[i].res, tbl[i].exp);
      chk("k0_bin", cap[i].bin, i);
      chk("k0_sop", cap[i].sop, i == 0);
      chk("k0_eop", cap[i].eop, i == N - 1);
    end

    // k=2: 100,100,400,400 -> 250, nothing before the last frame.
    cap.delete();
    drive_frame(6, 8, 2);
    drive_frame(6, 8, 2);
    drive_frame(0, 20, 2);
    idle(6);
    chk("k2_no_early_out", cap.size(), 0);
    drive_frame(0, 20, 2);
    idle(6);
    chk("k2_count", cap.size(), N);
    for (int i = 0; i < cap.size(); i++) chk("k2_mean", cap[i].res, 250);

    // Framing error at bin 5 of the first frame of a k=1 batch.
    cap.delete();
    e0 = err_seen;
    for (int b = 0; b < 5; b++) drive(1, b == 0, 3, 3, 1);
    drive_frame(4, 2, 1);
    drive_frame(12, 6, 1);
    idle(6);
    chk("err_pulses", err_seen - e0, 1);
    chk("err_count", cap.size(), N);
    for (int i = 0; i < cap.size(); i++) chk("err_mean", cap[i].res, 100);

    // Random data, k=1: gap-free reference run, then 50% gaps.
    for (int i = 0; i < 4*N; i++) begin
      rre[i] = int'($urandom_range(0, 65535)) - 32768;
      rim[i] = int'($urandom_range(0, 65535)) - 32768;
    end
    cap.delete();
    for (int i = 0; i < 4*N; i++) drive(1, (i % N) == 0, rre[i], rim[i], 1);
    idle(6);
    ref_cap = cap;
    chk("rand_nogap_count", ref_cap.size(), 2*N);
    cap.delete();
    for (int i = 0; i < 4*N; i++) begin
      while ($urandom_range(0, 1) == 1)
        drive(0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 65535)) - 32768, 5, 1);
      drive(1, (i % N) == 0, rre[i], rim[i], 1);
    end
    idle(6);
    chk("rand_gap_count", cap.size(), 2*N);
    for (int i = 0; i < cap.size() && i < ref_cap.size(); i++)
      chk("rand_gap_vs_nogap", cap[i].res, ref_cap[i].res);

    // avg_log2 1->0 mid-batch: batch still averages over 2.
    cap.delete();
    drive_frame(6, 8, 1);
    drive_frame(0, 20, 0);
    drive_frame(1, 2, 0);
    drive_frame(2, 3, 0);
    idle(6);
    chk("kchg_count", cap.size(), 3*N);
    if (cap.size() == 3*N) begin
      chk("kchg_batch_mean", cap[0].res, 250);
      chk("kchg_next_f0", cap[N].res, 5);
      chk("kchg_next_f1", cap[2*N].res, 13);
    end

    // avg_log2 above AVG_W clamps to 16 frames.
    cap.delete();
    for (int f = 0; f < 16; f++) begin
      if (f % 2 == 0) drive_frame(6, 8, 7);
      else            drive_frame(0, 20, 7);
    end
    idle(6);
    chk("clamp_count", cap.size(), N);
    if (cap.size() > 0) chk("clamp_mean", cap[0].res, 250);

    // Reset in the middle of output, then resync on the next sop only.
    drive_frame(6, 8, 1);
    for (int b = 0; b < 5; b++) drive(1, b == 0, 0, 20, 1);
    apply_reset();
    cap.delete();
    for (int b = 0; b < 5; b++) drive(1, 0, 7, 7, 0);
    idle(6);
    chk("resync_drop", cap.size(), 0);
    drive_frame(3, -4, 0);
    idle(6);
    chk("resync_count", cap.size(), N);
    if (cap.size() > 0) chk("resync_first", cap[0].res, 25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
